// File: rtl/raccoon_ram_pkg.sv
// Shared types and widths for the Raccoon single-port RAM and its masters.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package raccoon_ram_pkg;

  localparam int RAM_ADDR_W = 20;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_MASK_W = 4;

  // One RAM cycle's worth of command fields, as seen at the macro pins.
  typedef struct packed {
    logic                  cs;
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_MASK_W-1:0] mask;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

  // The RAM is word-addressed; byte-lane bits of the bus address are dropped.
  function automatic logic [RAM_ADDR_W-1:0] word_addr(input logic [RAM_ADDR_W-1:0] addr);
    return addr & ~RAM_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/ram_arb2_wait_mon.sv
// Tracks how long port B waits for a grant; flags starvation and records the worst wait.
// Latency: counter, STARVE and B_WAIT_MAX update on the clock edge after the cycle observed.
// Backpressure: none; purely observes the B request/ack handshake.
module ram_arb2_wait_mon #(
  parameter int CNT_W        = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b_req,
  input  logic             b_ack,
  input  logic             starve_clr,
  output logic             starve,
  output logic [CNT_W-1:0] b_wait_max
);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting = b_req & ~b_ack;

  // Consecutive wait cycles of the current B request; saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!waiting) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky starvation flag; a new starvation event beats a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= 1'b0;
    end else if (waiting && (wait_cnt == CNT_W'(STARVE_LIMIT - 1))) begin
      starve <= 1'b1;
    end else if (starve_clr) begin
      starve <= 1'b0;
    end
  end

  // Worst wait seen at grant time; a new maximum beats a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_wait_max <= '0;
    end else if (b_ack && (wait_cnt > b_wait_max)) begin
      b_wait_max <= wait_cnt;
    end else if (starve_clr) begin
      b_wait_max <= '0;
    end
  end

endmodule

// File: rtl/ram_arb2.sv
// Two-master arbiter for one single-port RAM: port A (fixed-latency bridge) always wins, port B takes idle cycles.
// Latency: grant is same-cycle; A read data 1 cycle after access; B read data registered, valid 2 cycles after B_ACK.
// Backpressure: A is never stalled; B holds B_REQ until B_ACK and is held off whenever A_CS is high.
module ram_arb2
  import raccoon_ram_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  A_CS,
  input  logic                  A_WE,
  input  logic [RAM_ADDR_W-1:0] A_ADDR,
  input  logic [RAM_MASK_W-1:0] A_MASK,
  input  logic [RAM_DATA_W-1:0] A_WR_DATA,
  output logic [RAM_DATA_W-1:0] A_RD_DATA,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [RAM_ADDR_W-1:0] B_ADDR,
  input  logic [RAM_MASK_W-1:0] B_MASK,
  input  logic [RAM_DATA_W-1:0] B_WR_DATA,
  output logic                  B_ACK,
  output logic                  B_RD_VALID,
  output logic [RAM_DATA_W-1:0] B_RD_DATA,
  output logic                  RAM_CS,
  output logic                  RAM_WE,
  output logic [RAM_ADDR_W-1:0] RAM_ADDR,
  output logic [RAM_MASK_W-1:0] RAM_MASK,
  output logic [RAM_DATA_W-1:0] RAM_WR_DATA,
  input  logic [RAM_DATA_W-1:0] RAM_RD_DATA,
  input  logic                  STARVE_CLR,
  output logic                  STARVE,
  output logic [CNT_W-1:0]      B_WAIT_MAX
);

  ram_req_t a_cmd, b_cmd, ram_cmd;
  logic     a_sel, b_sel;
  logic     rd_pend;

  // Grants are gated by reset so nothing reaches the macro while RST_N is low.
  assign a_sel = A_CS & RST_N;
  assign b_sel = B_REQ & ~A_CS & RST_N;

  assign a_cmd = '{cs: 1'b1, we: A_WE, addr: word_addr(A_ADDR), mask: A_MASK, wdata: A_WR_DATA};
  assign b_cmd = '{cs: 1'b1, we: B_WE, addr: word_addr(B_ADDR), mask: B_MASK, wdata: B_WR_DATA};

  // Fixed-priority mux onto the RAM pins; idle cycles drive all zeros.
  always_comb begin
    ram_cmd = '0;
    if (a_sel) begin
      ram_cmd = a_cmd;
    end else if (b_sel) begin
      ram_cmd = b_cmd;
    end
  end

  assign RAM_CS      = ram_cmd.cs;
  assign RAM_WE      = ram_cmd.we;
  assign RAM_ADDR    = ram_cmd.addr;
  assign RAM_MASK    = ram_cmd.mask;
  assign RAM_WR_DATA = ram_cmd.wdata;

  assign B_ACK     = b_sel;
  assign A_RD_DATA = RAM_RD_DATA;

  // B read return: the RAM data in the cycle after a B read ack belongs to that read,
  // whatever A does in that cycle, so capture it unconditionally on rd_pend.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_pend    <= 1'b0;
      B_RD_VALID <= 1'b0;
      B_RD_DATA  <= '0;
    end else begin
      rd_pend    <= b_sel & ~B_WE;
      B_RD_VALID <= rd_pend;
      if (rd_pend) begin
        B_RD_DATA <= RAM_RD_DATA;
      end
    end
  end

  ram_arb2_wait_mon #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_wait_mon (
    .clk        (CLK),
    .rst_n      (RST_N),
    .b_req      (B_REQ),
    .b_ack      (B_ACK),
    .starve_clr (STARVE_CLR),
    .starve     (STARVE),
    .b_wait_max (B_WAIT_MAX)
  );

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a behavioural RAM and a B read-return scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_arb2;
  import raccoon_ram_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        A_CS, A_WE;
  logic [19:0] A_ADDR;
  logic [3:0]  A_MASK;
  logic [31:0] A_WR_DATA, A_RD_DATA;
  logic        B_REQ, B_WE;
  logic [19:0] B_ADDR;
  logic [3:0]  B_MASK;
  logic [31:0] B_WR_DATA;
  logic        B_ACK, B_RD_VALID;
  logic [31:0] B_RD_DATA;
  logic        RAM_CS, RAM_WE;
  logic [19:0] RAM_ADDR;
  logic [3:0]  RAM_MASK;
  logic [31:0] RAM_WR_DATA, RAM_RD_DATA;
  logic        STARVE_CLR, STARVE;
  logic [7:0]  B_WAIT_MAX;

  always #5 CLK = ~CLK;

  ram_arb2 #(.CNT_W(8), .STARVE_LIMIT(64)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_CS(A_CS), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_MASK(A_MASK),
    .A_WR_DATA(A_WR_DATA), .A_RD_DATA(A_RD_DATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_MASK(B_MASK),
    .B_WR_DATA(B_WR_DATA), .B_ACK(B_ACK), .B_RD_VALID(B_RD_VALID), .B_RD_DATA(B_RD_DATA),
    .RAM_CS(RAM_CS), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_MASK(RAM_MASK),
    .RAM_WR_DATA(RAM_WR_DATA), .RAM_RD_DATA(RAM_RD_DATA),
    .STARVE_CLR(STARVE_CLR), .STARVE(STARVE), .B_WAIT_MAX(B_WAIT_MAX)
  );

  // Behavioural single-port RAM, 1-cycle read latency, byte-masked writes.
  logic [31:0] mem [int unsigned];
  logic [31:0] ram_q = '0;
  assign RAM_RD_DATA = ram_q;

  always @(posedge CLK) begin
    if (RAM_CS) begin
      if (RAM_WE) begin
        logic [31:0] w;
        w = mem.exists(int'(RAM_ADDR >> 2)) ? mem[int'(RAM_ADDR >> 2)] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (RAM_MASK[b]) w[b*8 +: 8] = RAM_WR_DATA[b*8 +: 8];
        mem[int'(RAM_ADDR >> 2)] = w;
      end else begin
        ram_q <= mem.exists(int'(RAM_ADDR >> 2)) ? mem[int'(RAM_ADDR >> 2)] : 32'h0;
      end
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // B read returns are matched in issue order against data and due cycle.
  always @(negedge CLK) begin
    if (B_RD_VALID) begin
      if (sbq.size() == 0) begin
        chk("b_rd_valid_unexpected", 64'(B_RD_VALID), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("b_rd_data", 64'(B_RD_DATA), 64'(e.data));
        chk("b_rd_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic b_drive(input logic we, input logic [19:0] addr, input logic [3:0] mask,
                         input logic [31:0] data);
    B_REQ = 1'b1; B_WE = we; B_ADDR = addr; B_MASK = mask; B_WR_DATA = data;
  endtask

  task automatic push_rd(input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + 2;
    sbq.push_back(e);
  endtask

  initial begin
    // Reset with both masters requesting.
    RST_N = 1'b0; STARVE_CLR = 1'b0;
    A_CS = 1'b1; A_WE = 1'b0; A_ADDR = '0; A_MASK = '0; A_WR_DATA = '0;
    b_drive(1'b0, 20'h0, 4'h0, 32'h0);
    @(negedge CLK);
    chk("rst_ram_cs", 64'(RAM_CS), 64'd0);
    chk("rst_b_ack", 64'(B_ACK), 64'd0);
    chk("rst_starve", 64'(STARVE), 64'd0);
    chk("rst_wait_max", 64'(B_WAIT_MAX), 64'd0);
    chk("rst_b_rd_valid", 64'(B_RD_VALID), 64'd0);
    chk("rst_b_rd_data", 64'(B_RD_DATA), 64'd0);
    step();
    A_CS = 1'b0; B_REQ = 1'b0; RST_N = 1'b1;
    step();

    // B write then B read of the same word.
    b_drive(1'b1, 20'h00104, 4'hF, 32'hDEADBEEF);
    @(negedge CLK);
    chk("wr_b_ack", 64'(B_ACK), 64'd1);
    chk("wr_ram_we", 64'(RAM_WE), 64'd1);
    chk("wr_ram_mask", 64'(RAM_MASK), 64'hF);
    chk("wr_ram_addr", 64'(RAM_ADDR), 64'h00104);
    chk("wr_ram_data", 64'(RAM_WR_DATA), 64'hDEADBEEF);
    step();
    b_drive(1'b0, 20'h00104, 4'hF, 32'h0);
    @(negedge CLK);
    chk("rd_b_ack", 64'(B_ACK), 64'd1);
    chk("rd_ram_we", 64'(RAM_WE), 64'd0);
    push_rd(32'hDEADBEEF);
    step();
    B_REQ = 1'b0;
    step(); step();

    // Collision: A wins, B is granted the following cycle after one wait.
    A_CS = 1'b1; A_WE = 1'b1; A_ADDR = 20'h20003; A_MASK = 4'h3; A_WR_DATA = 32'hA5A5A5A5;
    b_drive(1'b1, 20'h20010, 4'hF, 32'h12345678);
    @(negedge CLK);
    chk("col_ram_cs", 64'(RAM_CS), 64'd1);
    chk("col_ram_addr_a", 64'(RAM_ADDR), 64'h20000);
    chk("col_ram_mask_a", 64'(RAM_MASK), 64'h3);
    chk("col_ram_data_a", 64'(RAM_WR_DATA), 64'hA5A5A5A5);
    chk("col_b_ack_lost", 64'(B_ACK), 64'd0);
    step();
    A_CS = 1'b0;
    @(negedge CLK);
    chk("col_b_ack", 64'(B_ACK), 64'd1);
    chk("col_ram_addr_b", 64'(RAM_ADDR), 64'h20010);
    step();
    B_REQ = 1'b0;
    @(negedge CLK);
    chk("col_wait_max", 64'(B_WAIT_MAX), 64'd1);
    chk("col_idle_cs", 64'(RAM_CS), 64'd0);
    step();

    // Interleaved reads: A at T, B at T+1, then an A read right after the B ack.
    mem[32'h10000 >> 2] = 32'h11111111;
    mem[32'h10008 >> 2] = 32'h22222222;
    A_CS = 1'b1; A_WE = 1'b0; A_ADDR = 20'h10000;
    step();
    A_ADDR = 20'h00104;
    A_CS = 1'b0;
    b_drive(1'b0, 20'h10008, 4'h0, 32'h0);
    @(negedge CLK);
    chk("il_b_ack", 64'(B_ACK), 64'd1);
    chk("il_a_rd_data", 64'(A_RD_DATA), 64'h11111111);
    push_rd(32'h22222222);
    step();
    B_REQ = 1'b0;
    A_CS = 1'b1;
    step();
    A_CS = 1'b0;
    @(negedge CLK);
    chk("il_a_rd_data2", 64'(A_RD_DATA), 64'hDEADBEEF);
    step(); step();

    // Four back-to-back B reads.
    for (int i = 0; i < 4; i++) mem[(32'h30000 >> 2) + i] = 32'hC0DE0000 + i;
    for (int i = 0; i < 4; i++) begin
      b_drive(1'b0, 20'h30000 + 20'(4 * i), 4'h0, 32'h0);
      @(negedge CLK);
      chk("b2b_b_ack", 64'(B_ACK), 64'd1);
      push_rd(32'hC0DE0000 + i);
      step();
    end
    B_REQ = 1'b0;
    step(); step(); step();

    // Starvation: A holds the RAM for 70 cycles while B waits.
    A_CS = 1'b1; A_WE = 1'b0; A_ADDR = 20'h0;
    b_drive(1'b1, 20'h40000, 4'hF, 32'hFEEDFACE);
    for (int i = 0; i < 70; i++) begin
      @(negedge CLK);
      chk("stv_starve", 64'(STARVE), 64'(i >= 64));
      chk("stv_b_ack", 64'(B_ACK), 64'd0);
      step();
    end
    A_CS = 1'b0;
    @(negedge CLK);
    chk("stv_b_ack_late", 64'(B_ACK), 64'd1);
    step();
    B_REQ = 1'b0;
    @(negedge CLK);
    chk("stv_wait_max", 64'(B_WAIT_MAX), 64'd70);
    chk("stv_starve_hold", 64'(STARVE), 64'd1);
    step();
    STARVE_CLR = 1'b1;
    step();
    STARVE_CLR = 1'b0;
    @(negedge CLK);
    chk("clr_starve", 64'(STARVE), 64'd0);
    chk("clr_wait_max", 64'(B_WAIT_MAX), 64'd0);
    step();
    step();

    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ram_arb2.md
Name: ram_arb2

Overview:
- Two-master arbiter for one single-port synchronous RAM (1-cycle read latency, byte-mask writes).
- Port A is the fixed-latency Raccoon RAM bridge. It cannot stall, so it always wins.
- Port B is a req/ack master (DMA or core-side) that takes idle RAM cycles. It gets registered read return and starvation monitoring.
- Sits between the bus bridge, the secondary master and the RAM macro.

Parameters:
- CNT_W, 8: width of the B wait counter and of B_WAIT_MAX.
- STARVE_LIMIT, 64: B wait cycles at which STARVE sets. Must be below 2^CNT_W.

Ports:
- CLK  in  1  clock
- RST_N  in  1  async active-low reset
- A_CS  in  1  port A access strobe, single cycle per access
- A_WE  in  1  port A write
- A_ADDR  in  20  port A byte address, [1:0] ignored
- A_MASK  in  4  port A byte-write mask
- A_WR_DATA  in  32  port A write data
- A_RD_DATA  out  32  RAM_RD_DATA passthrough. Valid the cycle after an A read.
- B_REQ  in  1  port B request. Fields below held stable until B_ACK.
- B_WE  in  1  port B write
- B_ADDR  in  20  port B byte address
- B_MASK  in  4  port B byte-write mask
- B_WR_DATA  in  32  port B write data
- B_ACK  out  1  B access issued to RAM this cycle
- B_RD_VALID  out  1  one-cycle pulse: B_RD_DATA valid
- B_RD_DATA  out  32  registered B read data, held until the next B read return
- RAM_CS  out  1  RAM chip select
- RAM_WE  out  1  RAM write enable
- RAM_ADDR  out  20  RAM address, {addr[19:2],2'b00}
- RAM_MASK  out  4  RAM byte mask
- RAM_WR_DATA  out  32  RAM write data
- RAM_RD_DATA  in  32  RAM read data, 1 cycle after CS&~WE
- STARVE_CLR  in  1  clears STARVE and B_WAIT_MAX
- STARVE  out  1  sticky: B waited >= STARVE_LIMIT cycles
- B_WAIT_MAX  out  CNT_W  maximum B wait observed since clear

Behaviour:
- Clocking and reset:
  - Single clock CLK. Reset RST_N is asynchronous and active-low.
  - All flops reset to 0.
  - While RST_N=0: RAM_CS=0, B_ACK=0, B_RD_VALID=0, B_RD_DATA=0, STARVE=0, B_WAIT_MAX=0.
- Grant (combinational, same cycle):
  - a_sel = A_CS.
  - b_sel = B_REQ & ~A_CS.
  - RAM_* are driven from A when a_sel, from B when b_sel. Otherwise RAM_CS=0 and the other RAM_* outputs are 0.
  - B_ACK = b_sel. A_CS and B_REQ in the same cycle: A issued, B_ACK=0, B retries next cycle.
- Port A:
  - Zero added latency.
  - A_RD_DATA = RAM_RD_DATA unconditionally. The A master samples it the cycle after its read.
- Port B handshake:
  - A request completes in the cycle B_ACK=1.
  - B_REQ may stay high after ACK. A new request (new fields) is then issued at the earliest in the next cycle, giving 1 access/cycle back-to-back.
  - Dropping B_REQ before ACK withdraws the request. Legal; no RAM access occurs.
- B read pipeline:
  - Read ACK at cycle T sets rd_pend (reg) at T+1.
  - At the end of T+1, RAM_RD_DATA is captured into B_RD_DATA and B_RD_VALID=1 during T+2.
  - Read-to-valid = 2 cycles. Back-to-back reads pipeline at 1/cycle.
  - A writes or reads at T+1 do not disturb the capture, since RAM data at T+1 belongs to the T access.
- Wait counter (CNT_W bits):
  - Clears to 0 on B_ACK or ~B_REQ.
  - Increments on B_REQ & ~B_ACK, saturating at all-ones (no wrap).
- STARVE:
  - Sets when wait counter == STARVE_LIMIT-1 and B waits again that cycle.
  - Sticky until STARVE_CLR. Set and clear in the same cycle: set wins.
- B_WAIT_MAX:
  - Updated to the wait count when B_ACK=1 and wait count > B_WAIT_MAX.
  - STARVE_CLR zeroes it, but a concurrent update wins.
- Reset mid-operation:
  - A pending rd_pend or B_RD_VALID is lost.
  - The B master must re-issue after reset.

Decomposition:
- Package raccoon_ram_pkg: RAM_ADDR_W=20, RAM_DATA_W=32, RAM_MASK_W=4, and a ram_req typedef {cs,we,addr,mask,wdata}.
- Sub-module ram_arb2_wait_mon holds the wait counter, STARVE and B_WAIT_MAX.
- Grant mux and read pipeline stay in the top.

Test Plan:
- Reset: assert RST_N=0 with B_REQ=1 and A_CS=1 -> RAM_CS=0, B_ACK=0, STARVE=0, B_WAIT_MAX=0.
- B write then read:
  - Stimulus: B write addr 0x00104, mask 0xF, data 0xDEADBEEF with A idle; then a B read of the same address.
  - Response: B_ACK in the request cycle, RAM_WE=1 with mask 0xF; read B_RD_VALID 2 cycles after its ACK with B_RD_DATA=0xDEADBEEF.
- Collision:
  - Stimulus: A_CS and B_REQ high in the same cycle.
  - Response: RAM driven by A, B_ACK=0; next cycle with A idle B_ACK=1 with the B address on RAM_ADDR; B_WAIT_MAX=1.
- Interleaved reads:
  - Stimulus: A read 0x10000 at T, B read 0x10008 at T+1, with RAM preloaded 0x11111111 / 0x22222222.
  - Response: A_RD_DATA=0x11111111 at T+1; B_RD_VALID at T+3 with 0x22222222.
- Starvation:
  - Stimulus: A_CS held 70 cycles with B_REQ=1.
  - Response: STARVE rises after 64 waits; B_ACK when A drops; B_WAIT_MAX=70; STARVE_CLR then clears both.
- Back-to-back B reads:
  - Stimulus: 4 B reads on consecutive cycles, no A traffic.
  - Response: 4 consecutive B_RD_VALID pulses with data in issue order.
